// File: rtl/had_dbg_entry_ctrl_pkg.sv
// Shared definitions for the debug-entry controller.
//   dbg_state_e : 2-bit FSM state encoding (IDLE/REQ/DEBUG/EXIT)
//   CAUSE_*     : 3-bit debug-entry cause codes (0 = none)
//   sel_cause   : fixed-priority encoder from request lines to cause code
package had_dbg_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DEBUG = 2'd2,
    ST_EXIT  = 2'd3
  } dbg_state_e;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_DR    = 3'd1;
  localparam logic [2:0] CAUSE_JDB   = 3'd2;
  localparam logic [2:0] CAUSE_IBKPT = 3'd3;
  localparam logic [2:0] CAUSE_MBKPT = 3'd4;
  localparam logic [2:0] CAUSE_TRACE = 3'd5;

  // Priority, highest first: dr, jdb, ibkpt, mbkpt, trace.
  function automatic logic [2:0] sel_cause(input logic dr, input logic jdb,
                                           input logic ibkpt, input logic mbkpt,
                                           input logic trace);
    logic [2:0] c;
    c = CAUSE_NONE;
    if (trace) c = CAUSE_TRACE;
    if (mbkpt) c = CAUSE_MBKPT;
    if (ibkpt) c = CAUSE_IBKPT;
    if (jdb)   c = CAUSE_JDB;
    if (dr)    c = CAUSE_DR;
    return c;
  endfunction

endpackage

// File: rtl/had_dbg_tmo_cnt.sv
// Acknowledge-timeout down-counter for the debug-entry controller.
//   had_clk/had_rst : clock, asynchronous active-high reset (count -> 0)
//   load/load_val   : load the timeout value (takes precedence over dec)
//   dec             : decrement by one; a count of 0 never decrements
//   expire          : count currently equals 1 (last cycle before timeout)
// A loaded value of 0 therefore never expires, which disables the timeout.
module had_dbg_tmo_cnt #(
  parameter int TMO_W = 8
) (
  input  logic             had_clk,
  input  logic             had_rst,
  input  logic             load,
  input  logic [TMO_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  localparam logic [TMO_W-1:0] CNT_ZERO = '0;
  localparam logic [TMO_W-1:0] CNT_ONE  = TMO_W'(1);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != CNT_ZERO)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge had_clk or posedge had_rst) begin
    if (had_rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_ONE);

endmodule

// File: rtl/had_dbg_entry_ctrl.sv
// Debug-mode entry/exit controller.
//   Inputs : had_clk, had_rst (async, active high); request levels had_dr_req,
//            had_jdb_req, had_ibkpt_req, had_mbkpt_req, had_trace_req,
//            had_exit_req; IU status iu_had_dbg_disable_for_tee,
//            iu_had_dbg_ack, iu_yy_xx_dbgon; cfg_tmo (ack timeout, 0 = none).
//   Outputs: had_iu_dbg_req (high in REQ), had_dbg_cause, had_yy_xx_dbg
//            (high in DEBUG), had_yy_xx_exit_dbg (first EXIT cycle),
//            had_dbg_tmo_err (sticky), had_dbg_busy (not IDLE),
//            had_dbg_state (current FSM state, for observation).
// Handshake: the entry request is a level held from the cycle after a source
// is seen in IDLE until iu_had_dbg_ack is sampled high (-> DEBUG) or the
// timeout expires (-> IDLE). Sources are only looked at while in IDLE.
module had_dbg_entry_ctrl
  import had_dbg_entry_ctrl_pkg::*;
#(
  parameter int TMO_W = 8
) (
  input  logic             had_clk,
  input  logic             had_rst,
  input  logic             had_dr_req,
  input  logic             had_jdb_req,
  input  logic             had_ibkpt_req,
  input  logic             had_mbkpt_req,
  input  logic             had_trace_req,
  input  logic             had_exit_req,
  input  logic             iu_had_dbg_disable_for_tee,
  input  logic             iu_had_dbg_ack,
  input  logic             iu_yy_xx_dbgon,
  input  logic [TMO_W-1:0] cfg_tmo,
  output logic             had_iu_dbg_req,
  output logic [2:0]       had_dbg_cause,
  output logic             had_yy_xx_dbg,
  output logic             had_yy_xx_exit_dbg,
  output logic             had_dbg_tmo_err,
  output logic             had_dbg_busy,
  output logic [1:0]       had_dbg_state
);

  dbg_state_e state_q, state_d;
  logic [2:0] cause_q, cause_d;
  logic       tmo_err_q, tmo_err_d;
  logic       exit_hold_q, exit_hold_d;

  logic       any_req;
  logic       cnt_load;
  logic       cnt_dec;
  logic       tmo_expire;

  assign any_req = had_dr_req | had_jdb_req | had_ibkpt_req |
                   had_mbkpt_req | had_trace_req;

  // State register (plus the few flops that travel with the state).
  always_ff @(posedge had_clk or posedge had_rst) begin
    if (had_rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      tmo_err_q   <= 1'b0;
      exit_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      tmo_err_q   <= tmo_err_d;
      exit_hold_q <= exit_hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    tmo_err_d = tmo_err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req && !iu_had_dbg_disable_for_tee) begin
          state_d = ST_REQ;
          cause_d = sel_cause(had_dr_req, had_jdb_req, had_ibkpt_req,
                              had_mbkpt_req, had_trace_req);
        end
      end
      ST_REQ: begin
        // Ack is checked first so it wins over a same-cycle expiry.
        if (iu_had_dbg_ack) begin
          state_d   = ST_DEBUG;
          tmo_err_d = 1'b0;
        end else if (tmo_expire) begin
          state_d   = ST_IDLE;
          tmo_err_d = 1'b1;
          cause_d   = CAUSE_NONE;
        end
      end
      ST_DEBUG: begin
        if (had_exit_req && iu_yy_xx_dbgon) begin
          state_d = ST_EXIT;
        end
      end
      ST_EXIT: begin
        if (!iu_yy_xx_dbgon) begin
          state_d = ST_IDLE;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // Remembers that the previous cycle was already in EXIT, so the exit
  // pulse covers only the first EXIT cycle.
  assign exit_hold_d = (state_q == ST_EXIT);

  assign cnt_load = (state_q == ST_IDLE) && (state_d == ST_REQ);
  assign cnt_dec  = (state_q == ST_REQ) && !iu_had_dbg_ack;

  had_dbg_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo_cnt (
    .had_clk  (had_clk),
    .had_rst  (had_rst),
    .load     (cnt_load),
    .load_val (cfg_tmo),
    .dec      (cnt_dec),
    .expire   (tmo_expire)
  );

  // Output logic.
  always_comb begin
    had_iu_dbg_req     = (state_q == ST_REQ);
    had_yy_xx_dbg      = (state_q == ST_DEBUG);
    had_yy_xx_exit_dbg = (state_q == ST_EXIT) && !exit_hold_q;
    had_dbg_busy       = (state_q != ST_IDLE);
    had_dbg_cause      = cause_q;
    had_dbg_tmo_err    = tmo_err_q;
    had_dbg_state      = state_q;
  end

endmodule

// File: tb/tb_had_dbg_entry_ctrl.sv
module tb_had_dbg_entry_ctrl;
  import had_dbg_entry_ctrl_pkg::*;

  localparam int TMO_W = 8;

  logic             had_clk;
  logic             had_rst;
  logic             had_dr_req, had_jdb_req, had_ibkpt_req, had_mbkpt_req;
  logic             had_trace_req, had_exit_req;
  logic             iu_had_dbg_disable_for_tee, iu_had_dbg_ack, iu_yy_xx_dbgon;
  logic [TMO_W-1:0] cfg_tmo;
  logic             had_iu_dbg_req;
  logic [2:0]       had_dbg_cause;
  logic             had_yy_xx_dbg, had_yy_xx_exit_dbg, had_dbg_tmo_err;
  logic             had_dbg_busy;
  logic [1:0]       had_dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;

  had_dbg_entry_ctrl #(.TMO_W(TMO_W)) dut (
    .had_clk                    (had_clk),
    .had_rst                    (had_rst),
    .had_dr_req                 (had_dr_req),
    .had_jdb_req                (had_jdb_req),
    .had_ibkpt_req              (had_ibkpt_req),
    .had_mbkpt_req              (had_mbkpt_req),
    .had_trace_req              (had_trace_req),
    .had_exit_req               (had_exit_req),
    .iu_had_dbg_disable_for_tee (iu_had_dbg_disable_for_tee),
    .iu_had_dbg_ack             (iu_had_dbg_ack),
    .iu_yy_xx_dbgon             (iu_yy_xx_dbgon),
    .cfg_tmo                    (cfg_tmo),
    .had_iu_dbg_req             (had_iu_dbg_req),
    .had_dbg_cause              (had_dbg_cause),
    .had_yy_xx_dbg              (had_yy_xx_dbg),
    .had_yy_xx_exit_dbg         (had_yy_xx_exit_dbg),
    .had_dbg_tmo_err            (had_dbg_tmo_err),
    .had_dbg_busy               (had_dbg_busy),
    .had_dbg_state              (had_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial had_clk = 1'b0;
  always #5 had_clk = ~had_clk;

  // ---------------- reference model ----------------
  // Phase flags rather than an encoded state; timeout kept as "cycles of
  // request still allowed" (0 = unlimited).
  bit m_in_req, m_in_dbg, m_in_exit, m_exit_first, m_err;
  int m_left;
  int m_cause;

  function automatic int spec_cause(bit dr, bit jdb, bit ib, bit mb, bit tr);
    if (dr)  return 1;
    if (jdb) return 2;
    if (ib)  return 3;
    if (mb)  return 4;
    if (tr)  return 5;
    return 0;
  endfunction

  task automatic model_reset();
    m_in_req = 0; m_in_dbg = 0; m_in_exit = 0; m_exit_first = 0;
    m_err = 0; m_left = 0; m_cause = 0;
  endtask

  // One clock edge worth of behaviour, using the inputs held at that edge.
  task automatic model_step();
    int c;
    c = spec_cause(had_dr_req, had_jdb_req, had_ibkpt_req, had_mbkpt_req, had_trace_req);
    if (m_in_req) begin
      if (iu_had_dbg_ack) begin
        m_in_req = 0; m_in_dbg = 1; m_err = 0;
      end else if (m_left == 1) begin
        m_in_req = 0; m_err = 1; m_cause = 0;
      end else if (m_left > 1) begin
        m_left = m_left - 1;
      end
    end else if (m_in_dbg) begin
      if (had_exit_req && iu_yy_xx_dbgon) begin
        m_in_dbg = 0; m_in_exit = 1; m_exit_first = 1;
      end
    end else if (m_in_exit) begin
      m_exit_first = 0;
      if (!iu_yy_xx_dbgon) begin
        m_in_exit = 0; m_cause = 0;
      end
    end else begin
      if (c != 0 && !iu_had_dbg_disable_for_tee) begin
        m_in_req = 1; m_cause = c; m_left = int'(cfg_tmo);
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] exp_st;
    exp_st = m_in_req ? ST_REQ : m_in_dbg ? ST_DEBUG : m_in_exit ? ST_EXIT : ST_IDLE;
    check_val({tag, ".req"},   8'(had_iu_dbg_req),     8'(m_in_req));
    check_val({tag, ".cause"}, 8'(had_dbg_cause),      8'(m_cause));
    check_val({tag, ".dbg"},   8'(had_yy_xx_dbg),      8'(m_in_dbg));
    check_val({tag, ".exit"},  8'(had_yy_xx_exit_dbg), 8'(m_in_exit && m_exit_first));
    check_val({tag, ".err"},   8'(had_dbg_tmo_err),    8'(m_err));
    check_val({tag, ".busy"},  8'(had_dbg_busy),       8'(m_in_req || m_in_dbg || m_in_exit));
    check_val({tag, ".state"}, 8'(had_dbg_state),      8'(exp_st));
  endtask

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    had_dr_req = 0; had_jdb_req = 0; had_ibkpt_req = 0; had_mbkpt_req = 0;
    had_trace_req = 0; had_exit_req = 0; iu_had_dbg_disable_for_tee = 0;
    iu_had_dbg_ack = 0; iu_yy_xx_dbgon = 0;
  endtask

  // Inputs are changed at the falling edge; model and DUT see them at the
  // next rising edge; outputs are compared at the following falling edge.
  task automatic tick(input string tag);
    @(posedge had_clk);
    model_step();
    @(negedge had_clk);
    check_all(tag);
  endtask

  // Asserted between edges; outputs must clear without any clock edge.
  task automatic async_reset(input string tag);
    #2;
    had_rst = 1;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(negedge had_clk);
    had_rst = 0;
    clear_inputs();
    check_all({tag, ".post"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int req_cycles;
    had_rst = 1;
    clear_inputs();
    cfg_tmo = '0;
    model_reset();
    @(negedge had_clk);
    @(negedge had_clk);
    check_all("reset");
    had_rst = 0;

    // Two sources together: jdb outranks ibkpt; ack moves to DEBUG.
    had_jdb_req = 1; had_ibkpt_req = 1; cfg_tmo = 8'd0;
    tick("jdb_ibkpt");
    check_val("jdb_ibkpt.cause_const", 8'(had_dbg_cause), 8'd2);
    had_jdb_req = 0; had_ibkpt_req = 0; iu_had_dbg_ack = 1;
    tick("ack");
    check_val("ack.dbg_const", 8'(had_yy_xx_dbg), 8'd1);
    iu_had_dbg_ack = 0; iu_yy_xx_dbgon = 1; had_exit_req = 1;
    tick("exit_first");
    check_val("exit_first.pulse_const", 8'(had_yy_xx_exit_dbg), 8'd1);
    had_exit_req = 0;
    for (int i = 0; i < 5; i++) tick("exit_hold");
    check_val("exit_hold.busy_const", 8'(had_dbg_busy), 8'd1);
    iu_yy_xx_dbgon = 0;
    tick("exit_done");

    // Timeout of 4 with no ack.
    cfg_tmo = 8'd4; had_mbkpt_req = 1;
    req_cycles = 0;
    tick("tmo4_enter");
    had_mbkpt_req = 0;
    if (had_iu_dbg_req) req_cycles++;
    for (int i = 0; i < 6; i++) begin
      tick("tmo4_run");
      if (had_iu_dbg_req) req_cycles++;
    end
    check_val("tmo4.req_cycles", 8'(req_cycles), 8'd4);
    check_val("tmo4.err_const", 8'(had_dbg_tmo_err), 8'd1);
    check_val("tmo4.cause_const", 8'(had_dbg_cause), 8'd0);

    // Timeout of 3 with ack landing in the expiry cycle.
    cfg_tmo = 8'd3; had_dr_req = 1;
    tick("tmo3_enter");
    had_dr_req = 0;
    tick("tmo3_c2");
    tick("tmo3_c1");
    iu_had_dbg_ack = 1;
    tick("tmo3_ack");
    check_val("tmo3.dbg_const", 8'(had_yy_xx_dbg), 8'd1);
    check_val("tmo3.err_const", 8'(had_dbg_tmo_err), 8'd0);
    iu_had_dbg_ack = 0; iu_yy_xx_dbgon = 1; had_exit_req = 1;
    tick("tmo3_exit");
    had_exit_req = 0; iu_yy_xx_dbgon = 0;
    tick("tmo3_idle");

    // TEE disable blocks entry; clearing it lets the held request in.
    cfg_tmo = 8'd0; iu_had_dbg_disable_for_tee = 1; had_trace_req = 1;
    for (int i = 0; i < 3; i++) tick("tee_block");
    check_val("tee_block.req_const", 8'(had_iu_dbg_req), 8'd0);
    iu_had_dbg_disable_for_tee = 0;
    tick("tee_open");
    check_val("tee_open.cause_const", 8'(had_dbg_cause), 8'd5);
    had_trace_req = 0; iu_had_dbg_disable_for_tee = 1;
    tick("tee_in_req");
    check_val("tee_in_req.req_const", 8'(had_iu_dbg_req), 8'd1);
    iu_had_dbg_disable_for_tee = 0;

    // Reset in the middle of REQ.
    for (int i = 0; i < 3; i++) tick("pre_rst");
    async_reset("rst_in_req");
    check_val("rst_in_req.busy_const", 8'(had_dbg_busy), 8'd0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      had_dr_req    = ($urandom_range(0, 9) == 0);
      had_jdb_req   = ($urandom_range(0, 9) == 0);
      had_ibkpt_req = ($urandom_range(0, 9) == 0);
      had_mbkpt_req = ($urandom_range(0, 9) == 0);
      had_trace_req = ($urandom_range(0, 9) == 0);
      had_exit_req  = ($urandom_range(0, 2) == 0);
      iu_had_dbg_disable_for_tee = ($urandom_range(0, 5) == 0);
      iu_had_dbg_ack = ($urandom_range(0, 3) == 0);
      if (m_in_dbg || m_in_exit) iu_yy_xx_dbgon = ($urandom_range(0, 3) != 0);
      else                       iu_yy_xx_dbgon = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 7) == 0) cfg_tmo = TMO_W'($urandom_range(0, 6));
      if ($urandom_range(0, 249) == 0) async_reset("rnd_rst");
      else tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/had_dbg_entry_ctrl.md
HAD_DBG_ENTRY_CTRL -- requirements
Module: had_dbg_entry_ctrl

Interface
REQ-001 SHALL have parameter TMO_W, default 8, width of the entry-timeout counter and of cfg_tmo.
REQ-002 SHALL have port had_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port had_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port had_dr_req, input, 1, debug-register set request (level).
REQ-005 SHALL have port had_jdb_req, input, 1, JTAG debug request (level).
REQ-006 SHALL have port had_ibkpt_req, input, 1, instruction breakpoint hit (level).
REQ-007 SHALL have port had_mbkpt_req, input, 1, memory breakpoint hit (level).
REQ-008 SHALL have port had_trace_req, input, 1, trace count expired (level).
REQ-009 SHALL have port had_exit_req, input, 1, request to leave debug mode (level).
REQ-010 SHALL have port iu_had_dbg_disable_for_tee, input, 1, blocks all new entries.
REQ-011 SHALL have port iu_had_dbg_ack, input, 1, IU accepted the entry request.
REQ-012 SHALL have port iu_yy_xx_dbgon, input, 1, IU is in debug mode.
REQ-013 SHALL have port cfg_tmo, input, TMO_W, ack timeout in cycles; 0 disables the timeout.
REQ-014 SHALL have port had_iu_dbg_req, output, 1, entry request to the IU.
REQ-015 SHALL have port had_dbg_cause, output, 3, cause of the latched entry.
REQ-016 SHALL have port had_yy_xx_dbg, output, 1, high while in state DEBUG.
REQ-017 SHALL have port had_yy_xx_exit_dbg, output, 1, one-cycle exit pulse.
REQ-018 SHALL have port had_dbg_tmo_err, output, 1, sticky timeout flag.
REQ-019 SHALL have port had_dbg_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, REQ, DEBUG and EXIT.
REQ-021 In IDLE, when any request is high and iu_had_dbg_disable_for_tee=0, the block SHALL latch the cause and enter REQ on the next edge.
REQ-022 Cause priority SHALL be, highest first: dr=1, jdb=2, ibkpt=3, mbkpt=4, trace=5; 0 means none.
REQ-023 had_iu_dbg_req SHALL be 1 exactly while in REQ; request latency from source to had_iu_dbg_req SHALL be 1 cycle.
REQ-024 had_dbg_cause SHALL stay stable from entry to REQ until return to IDLE, and SHALL be cleared to 0 on return to IDLE.
REQ-025 Source changes while in REQ, DEBUG or EXIT SHALL be ignored.
REQ-026 In REQ, when iu_had_dbg_ack=1, the block SHALL enter DEBUG.
REQ-027 On entry to REQ, the counter SHALL load cfg_tmo, and SHALL decrement each cycle in REQ without ack.
REQ-028 When the counter equals 1 with no ack, the block SHALL go to IDLE and set had_dbg_tmo_err.
REQ-029 When cfg_tmo=0, no timeout SHALL occur.
REQ-030 When ack and expiry occur in the same cycle, ack SHALL win.
REQ-031 had_dbg_tmo_err SHALL be cleared only by reset, or when a later entry is acknowledged.
REQ-032 In DEBUG, had_yy_xx_dbg SHALL be 1.
REQ-033 In DEBUG, when had_exit_req=1 and iu_yy_xx_dbgon=1, the block SHALL enter EXIT.
REQ-034 had_yy_xx_exit_dbg SHALL be 1 for exactly the first cycle in EXIT.
REQ-035 The block SHALL stay in EXIT until iu_yy_xx_dbgon=0, then go to IDLE.
REQ-036 A request present in the cycle the FSM reaches IDLE SHALL be evaluated on the following edge; no request SHALL be lost if it is held.
REQ-037 Raising iu_had_dbg_disable_for_tee while in REQ SHALL NOT withdraw the request.

Reset
REQ-038 While had_rst=1, the state SHALL be IDLE, the counter 0, and had_iu_dbg_req, had_dbg_cause, had_yy_xx_dbg, had_yy_xx_exit_dbg, had_dbg_tmo_err and had_dbg_busy all 0.
REQ-039 Reset asserted mid-operation SHALL abort immediately with no exit pulse.

Structure
REQ-040 A shared package SHALL hold the state encoding (2 bits) and the cause code constants.
REQ-041 One sub-module, had_dbg_tmo_cnt (load/decrement/expire), SHALL be used; everything else SHALL be flat.

Verification
REQ-042 jdb_req=1 and ibkpt_req=1 together from IDLE -> req=1 after 1 cycle, cause=2; ack -> dbg=1.
REQ-043 cfg_tmo=4, mbkpt_req pulse, no ack -> req high for 4 cycles, then IDLE, tmo_err=1, cause=0.
REQ-044 cfg_tmo=3, ack in the expiry cycle -> DEBUG entered, tmo_err=0.
REQ-045 In DEBUG with dbgon=1, exit_req=1 -> one exit pulse; hold dbgon=1 for 5 cycles -> busy=1, no further pulse; dbgon=0 -> IDLE.
REQ-046 dbg_disable_for_tee=1 with trace_req=1 -> req stays 0; disable=0 -> req=1, cause=5.
REQ-047 had_rst pulse while in REQ -> all outputs 0 asynchronously, FSM in IDLE.
